// File: rtl/ysyx_24080006_pkg.sv
// rtl/ysyx_24080006_pkg.sv - shared types and constants for the iterative multiply/divide unit
package ysyx_24080006_pkg;

    localparam int MDU_ITER = 32;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    typedef struct packed {
        logic [32:0] a;
        logic [32:0] b;
    } mdu2alu_t;

    typedef struct packed {
        logic [33:0] res_34;
        logic [31:0] res_32;
        logic        not_zero;
    } alu2mdu_t;

    function automatic logic op_is_div(input mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input mdu_op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_signed_a(input mdu_op_e op);
        return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic op_signed_b(input mdu_op_e op);
        return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/ysyx_24080006_mdu.sv
// rtl/ysyx_24080006_mdu.sv - iterative RV32M multiply/divide unit borrowing the ALU adder
module ysyx_24080006_mdu
    import ysyx_24080006_pkg::*;
(
    input  logic        clock,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  mdu_op_e     mdu_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        mdu_enable,
    output mdu2alu_t    mdu2alu,
    input  alu2mdu_t    alu2mdu
);

    mdu_state_e  state_q;
    mdu_op_e     op_q;
    logic        neg_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] m_q;
    logic [4:0]  cnt_q;
    logic [31:0] result_q;

    logic        sa, sb, req_neg, div_zero, div_ovf;
    logic [31:0] mag_a, mag_b;
    logic [31:0] sum;
    logic        carry;
    logic [32:0] rs;
    logic        accept;
    logic [31:0] fix_v;
    logic        fix_neg, fix_hi_neg;
    logic        unused_ok;

    assign sa       = op_a[31] & op_signed_a(mdu_op);
    assign sb       = op_b[31] & op_signed_b(mdu_op);
    assign mag_a    = sa ? (~op_a + 32'd1) : op_a;
    assign mag_b    = sb ? (~op_b + 32'd1) : op_b;
    assign req_neg  = op_is_rem(mdu_op) ? sa : (sa ^ sb);
    assign div_zero = op_is_div(mdu_op) && (op_b == 32'd0);
    assign div_ovf  = (mdu_op == MDU_DIV || mdu_op == MDU_REM)
                      && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);

    assign sum       = alu2mdu.res_34[32:1];
    assign carry     = alu2mdu.res_34[33];
    assign unused_ok = ^{alu2mdu.res_34[0], alu2mdu.not_zero};

    // Restoring divide: remainder shifted left with the next dividend bit from Q.
    assign rs     = {hi_q, lo_q[31]};
    assign accept = rs[32] | carry;

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign mdu_enable = (state_q == CALC) || (state_q == FIX);
    assign result     = result_q;

    always_comb begin
        fix_v      = lo_q;
        fix_neg    = 1'b0;
        fix_hi_neg = 1'b0;
        case (op_q)
            MDU_MUL, MDU_DIV, MDU_DIVU: begin
                fix_v   = lo_q;
                fix_neg = neg_q;
            end
            MDU_MULH, MDU_MULHSU: begin
                fix_v      = hi_q;
                fix_hi_neg = neg_q;
            end
            MDU_MULHU: fix_v = hi_q;
            default: begin
                fix_v   = hi_q;
                fix_neg = neg_q;
            end
        endcase
    end

    always_comb begin
        mdu2alu = '0;
        if (state_q == CALC) begin
            if (op_is_div(op_q)) begin
                mdu2alu.a = {rs[31:0], 1'b1};
                mdu2alu.b = {~m_q, 1'b1};
            end else begin
                mdu2alu.a = {hi_q, 1'b0};
                mdu2alu.b = {(lo_q[0] ? m_q : 32'd0), 1'b0};
            end
        end else if (state_q == FIX) begin
            // High-word negation: ~hi plus a carry-in only when the low word is zero.
            if (fix_hi_neg) begin
                mdu2alu.a = {~hi_q, (lo_q == 32'd0)};
                mdu2alu.b = {32'd0, (lo_q == 32'd0)};
            end else if (fix_neg) begin
                mdu2alu.a = {32'd0, 1'b1};
                mdu2alu.b = {~fix_v, 1'b1};
            end else begin
                mdu2alu.a = {fix_v, 1'b0};
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= MDU_MUL;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q  <= mdu_op;
                    neg_q <= req_neg;
                    cnt_q <= '0;
                    hi_q  <= '0;
                    lo_q  <= mag_a;
                    m_q   <= mag_b;
                    if (div_zero) begin
                        result_q <= op_is_rem(mdu_op) ? op_a : 32'hFFFF_FFFF;
                        state_q  <= DONE;
                    end else if (div_ovf) begin
                        result_q <= op_is_rem(mdu_op) ? 32'd0 : 32'h8000_0000;
                        state_q  <= DONE;
                    end else begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (op_is_div(op_q)) begin
                        hi_q <= accept ? sum : rs[31:0];
                        lo_q <= {lo_q[30:0], accept};
                    end else begin
                        {hi_q, lo_q} <= {carry, sum, lo_q[31:1]};
                    end
                    if (cnt_q == 5'(MDU_ITER - 1)) state_q <= FIX;
                end
                FIX: begin
                    result_q <= alu2mdu.res_32;
                    state_q  <= DONE;
                end
                default: if (out_ready) state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mdu.sv
// tb/tb_ysyx_24080006_mdu.sv - directed self-checking bench for the multiply/divide unit
module tb_ysyx_24080006_mdu;
    import ysyx_24080006_pkg::*;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    mdu_op_e     mdu_op = MDU_MUL;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        mdu_enable;
    mdu2alu_t    mdu2alu;
    alu2mdu_t    alu2mdu;

    logic [32:0] alu_a, alu_b;
    logic [33:0] alu_sum;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    // Shared ALU adder: steered to the MDU only while mdu_enable is high.
    assign alu_a   = mdu_enable ? mdu2alu.a : 33'h1_2345_6789;
    assign alu_b   = mdu_enable ? mdu2alu.b : 33'h0_0F0F_0F0F;
    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu2mdu.res_34   = alu_sum;
    assign alu2mdu.res_32   = alu_sum[32:1];
    assign alu2mdu.not_zero = |alu_sum[32:1];

    ysyx_24080006_mdu dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mdu_op     (mdu_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .mdu_enable (mdu_enable),
        .mdu2alu    (mdu2alu),
        .alu2mdu    (alu2mdu)
    );

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        mdu_op   = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input mdu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input int hold);
        int  n;
        int  en;
        bit  done;
        n = 0; en = 0; done = 0;
        start_op(op, a, b);
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
            if (mdu_enable) en++;
            if (out_valid) done = 1;
        end
        check({tag, "_lat"}, 66'(n), 66'(exp_lat));
        check({tag, "_res"}, 66'(result), 66'(exp));
        check({tag, "_en"}, 66'(en), 66'(exp_lat == 34 ? 33 : 0));
        for (int i = 0; i < hold; i++) @(negedge clock);
        if (hold > 0) begin
            check({tag, "_hold_res"}, 66'(result), 66'(exp));
            check({tag, "_hold_busy"}, 66'({in_ready, out_valid}), 66'(2'b01));
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        check({tag, "_idle"}, 66'({in_ready, out_valid}), 66'(2'b10));
    endtask

    initial begin
        #12;
        check("rst_ready", 66'(in_ready), 66'(1));
        check("rst_valid", 66'(out_valid), 66'(0));
        check("rst_result", 66'(result), 66'(0));
        check("rst_enable", 66'(mdu_enable), 66'(0));
        check("rst_mdu2alu", 66'(mdu2alu), 66'(0));
        @(negedge clock);
        rst_n = 1'b1;

        run_op("mul_neg",  MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
        run_op("mulh_min", MDU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 0);
        run_op("mulhu_max",MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
        run_op("mulhsu",   MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
        run_op("div_neg",  MDU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 0);
        run_op("rem_neg",  MDU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 0);
        run_op("divu",     MDU_DIVU,   32'd100,        32'd7,         32'd14,        34, 0);
        run_op("remu",     MDU_REMU,   32'd100,        32'd7,         32'd2,         34, 0);
        run_op("div_zero", MDU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0);
        run_op("rem_zero", MDU_REM,    32'd5,          32'd0,         32'd5,         1,  0);
        run_op("div_ovf",  MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
        run_op("rem_ovf",  MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0);

        run_op("bp_mul",   MDU_MUL,    32'd1000,       32'd3000,      32'd3000000,   34, 5);
        run_op("b2b_divu", MDU_DIVU,   32'hFFFF_FFFF,  32'h0001_0000, 32'h0000_FFFF, 34, 0);

        start_op(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 10; i++) @(negedge clock);
        check("pre_flush_en", 66'(mdu_enable), 66'(1));
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        check("flush_state", 66'({in_ready, mdu_enable, out_valid}), 66'(3'b100));
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_valid) check("flush_no_valid", 66'(out_valid), 66'(0));
        end
        run_op("mulhu_aft_flush", MDU_MULHU, 32'h8000_0000, 32'd4, 32'd2, 34, 0);

        start_op(MDU_MUL, 32'd9, 32'd9);
        for (int i = 0; i < 20; i++) @(negedge clock);
        rst_n = 1'b0;
        #1;
        check("arst_state", 66'({in_ready, mdu_enable, out_valid}), 66'(3'b100));
        check("arst_result", 66'(result), 66'(0));
        #2 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_valid) check("arst_no_valid", 66'(out_valid), 66'(0));
        end
        run_op("mulhu_aft_rst", MDU_MULHU, 32'h0001_0000, 32'h0003_0000, 32'd3, 34, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
